// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and types used by the FC layer and the argmax stage.
package cnn_pkg;

  localparam int unsigned CLASS_NUM = 10;
  localparam int unsigned SCORE_W   = 12;
  localparam int unsigned IDX_W     = 4;

  typedef logic signed [SCORE_W-1:0] score_t;
  typedef logic [IDX_W-1:0]          class_idx_t;

  function automatic score_t SCORE_MIN();
    return {1'b1, {(SCORE_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/fc_argmax_if.sv
// Score stream in, classification decision out.
interface fc_argmax_if;
  import cnn_pkg::*;

  logic               valid_in;
  score_t             data_in;
  logic               valid_out;
  class_idx_t         class_out;
  score_t             max_score;
  logic [SCORE_W-1:0] margin;
  logic [7:0]         frame_cnt;

  modport master (
    output valid_in, data_in,
    input  valid_out, class_out, max_score, margin, frame_cnt
  );

  modport slave (
    input  valid_in, data_in,
    output valid_out, class_out, max_score, margin, frame_cnt
  );
endinterface

// File: rtl/score_rank.sv
// Combinational best/second-best update for one incoming class score.
module score_rank
  import cnn_pkg::*;
(
  input  score_t     sample_i,
  input  class_idx_t idx_i,
  input  logic       first_i,
  input  score_t     best_i,
  input  score_t     second_i,
  input  class_idx_t best_idx_i,
  output score_t     best_o,
  output score_t     second_o,
  output class_idx_t best_idx_o
);

  always_comb begin
    best_o     = best_i;
    second_o   = second_i;
    best_idx_o = best_idx_i;
    if (first_i) begin
      best_o     = sample_i;
      second_o   = SCORE_MIN();
      best_idx_o = '0;
    end else if (sample_i > best_i) begin
      // Strict compare: ties keep the earlier (lower) index.
      second_o   = best_i;
      best_o     = sample_i;
      best_idx_o = idx_i;
    end else if (sample_i > second_i) begin
      second_o = sample_i;
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// Argmax decision stage: ranks a frame of CLASS_NUM scores and emits winner, score and margin.
module fc_argmax
  import cnn_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fc_argmax_if.slave   bus_io
);

  localparam class_idx_t LastIdx = class_idx_t'(CLASS_NUM - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StEmit} state_e;

  state_e             state_q, state_d;
  class_idx_t         cls_idx_q, cls_idx_d;
  score_t             best_q, second_q;
  class_idx_t         best_idx_q;
  score_t             rank_best, rank_second;
  class_idx_t         rank_best_idx;
  class_idx_t         class_q;
  score_t             max_q;
  logic [SCORE_W-1:0] margin_q;
  logic [7:0]         frame_cnt_q;
  logic               accept, first, last;

  assign accept = bus_io.valid_in;
  assign first  = (cls_idx_q == '0);
  assign last   = accept && (cls_idx_q == LastIdx);

  score_rank u_score_rank (
    .sample_i   (bus_io.data_in),
    .idx_i      (cls_idx_q),
    .first_i    (first),
    .best_i     (best_q),
    .second_i   (second_q),
    .best_idx_i (best_idx_q),
    .best_o     (rank_best),
    .second_o   (rank_second),
    .best_idx_o (rank_best_idx)
  );

  always_comb begin
    cls_idx_d = cls_idx_q;
    if (accept) begin
      cls_idx_d = last ? '0 : cls_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StAcc;
      StAcc:   if (last) state_d = StEmit;
      StEmit:  state_d = accept ? StAcc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_io.valid_out = (state_q == StEmit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_idx_q   <= '0;
      best_q      <= SCORE_MIN();
      second_q    <= SCORE_MIN();
      best_idx_q  <= '0;
      class_q     <= '0;
      max_q       <= '0;
      margin_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      cls_idx_q <= cls_idx_d;
      if (accept) begin
        best_q     <= rank_best;
        second_q   <= rank_second;
        best_idx_q <= rank_best_idx;
      end
      if (last) begin
        class_q     <= rank_best_idx;
        max_q       <= rank_best;
        // best >= second, so the difference fits unsigned in SCORE_W bits even if the
        // signed subtraction wraps.
        margin_q    <= rank_best - rank_second;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign bus_io.class_out = class_q;
  assign bus_io.max_score = max_q;
  assign bus_io.margin    = margin_q;
  assign bus_io.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax.
module tb_fc_argmax;
  import cnn_pkg::*;

  typedef int frame_t [10];

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  fc_argmax_if bus_if ();

  fc_argmax dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus_if.valid_in = 1'b0;
    bus_if.data_in  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents one score for one edge; returns #1 after that edge.
  task automatic drive(input int s);
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = score_t'(s);
    @(posedge clk);
    #1;
    bus_if.valid_in = 1'b0;
  endtask

  task automatic send_frame(input frame_t sc, input int gap);
    for (int i = 0; i < 10; i++) begin
      drive(sc[i]);
      if (i == 8) check_eq("no_early_valid", int'(bus_if.valid_out), 0);
      if (i < 9) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_decision(input string tag, input int cls, input int mx, input int mg,
                                input int fc);
    check_eq({tag, "_valid"}, int'(bus_if.valid_out), 1);
    check_eq({tag, "_class"}, int'(bus_if.class_out), cls);
    check_eq({tag, "_max"}, int'(bus_if.max_score), mx);
    check_eq({tag, "_margin"}, int'(bus_if.margin), mg);
    check_eq({tag, "_frames"}, int'(bus_if.frame_cnt), fc);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse_end"}, int'(bus_if.valid_out), 0);
    check_eq({tag, "_hold"}, int'(bus_if.class_out), cls);
  endtask

  initial begin
    frame_t f;
    int     pulses;
    int     pulse_at [2];

    rst_n = 1'b1;
    do_reset();
    check_eq("rst_valid", int'(bus_if.valid_out), 0);
    check_eq("rst_class", int'(bus_if.class_out), 0);
    check_eq("rst_max", int'(bus_if.max_score), 0);
    check_eq("rst_margin", int'(bus_if.margin), 0);
    check_eq("rst_frames", int'(bus_if.frame_cnt), 0);

    // Tie on 100: lower index wins, margin 0.
    f = '{5, -3, 100, 7, 100, -2048, 0, 99, 1, 2};
    send_frame(f, 0);
    check_decision("tie", 2, 100, 0, 1);

    // Ascending with idle gaps.
    f = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
    send_frame(f, 3);
    check_decision("gaps", 9, 100, 10, 2);

    f = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    send_frame(f, 1);
    check_decision("allmin", 0, -2048, 0, 3);

    f = '{2047, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    send_frame(f, 0);
    check_decision("fullrange", 0, 2047, 4095, 4);

    // Back-to-back frames with valid_in held high throughout.
    do_reset();
    pulses = 0;
    pulse_at[0] = -1;
    pulse_at[1] = -1;
    for (int i = 0; i < 20; i++) begin
      drive((i == 4) ? 30 : (i == 17) ? -5 : (i < 10) ? 1 : -10);
      bus_if.valid_in = (i < 19);
      if (bus_if.valid_out) begin
        if (pulses < 2) pulse_at[pulses] = i;
        pulses++;
      end
      if (i == 9) begin
        check_eq("b2b_f1_class", int'(bus_if.class_out), 4);
        check_eq("b2b_f1_margin", int'(bus_if.margin), 29);
        check_eq("b2b_f1_frames", int'(bus_if.frame_cnt), 1);
      end
    end
    check_eq("b2b_pulses", pulses, 2);
    check_eq("b2b_first_at", pulse_at[0], 9);
    check_eq("b2b_second_at", pulse_at[1], 19);
    check_eq("b2b_f2_class", int'(bus_if.class_out), 7);
    check_eq("b2b_f2_max", int'(bus_if.max_score), -5);
    check_eq("b2b_f2_margin", int'(bus_if.margin), 5);
    check_eq("b2b_f2_frames", int'(bus_if.frame_cnt), 2);
    @(posedge clk);
    #1;
    check_eq("b2b_pulse_end", int'(bus_if.valid_out), 0);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 4; i++) drive(200);
    rst_n = 1'b0;
    #2;
    check_eq("midrst_class", int'(bus_if.class_out), 0);
    check_eq("midrst_frames", int'(bus_if.frame_cnt), 0);
    do_reset();
    f = '{0, 0, 0, 50, 0, 0, 0, 0, 0, 0};
    send_frame(f, 0);
    check_decision("midrst", 3, 50, 50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
